// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor control slice.
// Contents:
//   - pc_sel_t: next-PC mux select encoding driven on mux_signal.
//       PC_SEL_SEQ  = 0  pc+4
//       PC_SEL_PRED = 1  branch-table target
//       PC_SEL_FALL = 2  pc4_s4 (fall-through fix after a wrong "taken")
//       PC_SEL_TGT  = 3  baddr_s4 (target fix after a wrong "not taken")
package bp_pkg;
  typedef enum logic [1:0] {
    PC_SEL_SEQ  = 2'd0,
    PC_SEL_PRED = 2'd1,
    PC_SEL_FALL = 2'd2,
    PC_SEL_TGT  = 2'd3
  } pc_sel_t;
endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low clear
//   inc   - increment request for this cycle
//   cnt   - current count; holds at all-ones once reached
module bp_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (inc && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor control for the 5-stage MIPS pipeline.
// Steers the next-PC mux from the fetch-stage table lookup, resolves the
// branch in MEM (s4), flushes and redirects on a misprediction and commands
// branch-table updates. Decision logic is purely combinational.
// Optional statistics counters are built only when BP_STATS_EN is defined;
// otherwise p_acerto/p_erro are tied to zero.
// Ports:
//   clk, rst_n           - clock / async active-low reset (counters only)
//   hit_s1, p_s1         - fetch-stage table hit and taken prediction
//   hit_s4, p_s4         - the same lookup, pipelined to s4
//   branch_s4            - s4 holds beq/bne
//   deviated_s4          - actual s4 branch outcome (1 = taken)
//   mux_signal           - next-PC select (bp_pkg::pc_sel_t)
//   write_rp / write_rt  - update existing entry / allocate new entry
//   flush                - squash s1..s3
//   p_acerto / p_erro    - correct / wrong prediction counts (saturating)
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_s1,
  input  logic             p_s1,
  input  logic             hit_s4,
  input  logic             p_s4,
  input  logic             branch_s4,
  input  logic             deviated_s4,
  output pc_sel_t          mux_signal,
  output logic             write_rp,
  output logic             write_rt,
  output logic             flush,
  output logic [CNT_W-1:0] p_acerto,
  output logic [CNT_W-1:0] p_erro
);
  logic pred_s4;
  logic mispredict;

  assign pred_s4 = hit_s4 & p_s4;
  // Second term: a stale/aliased entry predicted taken on a non-branch.
  assign mispredict = (branch_s4 & (deviated_s4 != pred_s4)) | (~branch_s4 & pred_s4);

  // An s4 correction always wins over the s1 prediction.
  always_comb begin
    flush      = mispredict;
    mux_signal = PC_SEL_SEQ;
    if (mispredict)
      mux_signal = (branch_s4 & deviated_s4) ? PC_SEL_TGT : PC_SEL_FALL;
    else if (hit_s1 & p_s1)
      mux_signal = PC_SEL_PRED;
  end

  // Only real branches touch the table; aliasing just redirects.
  assign write_rp = branch_s4 & hit_s4;
  assign write_rt = branch_s4 & ~hit_s4;

`ifdef BP_STATS_EN
  bp_sat_counter #(.W(CNT_W)) u_acerto (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_s4 & ~mispredict),
    .cnt   (p_acerto)
  );

  bp_sat_counter #(.W(CNT_W)) u_erro (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispredict),
    .cnt   (p_erro)
  );
`else
  logic stats_unused;
  assign stats_unused = &{1'b0, clk, rst_n};
  assign p_acerto = '0;
  assign p_erro   = '0;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a
// behavioural model. Works with and without BP_STATS_EN.
module tb_branch_predict_ctrl;
  localparam int CNT_W = 32;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hit_s1 = 0, p_s1 = 0, hit_s4 = 0, p_s4 = 0, branch_s4 = 0, deviated_s4 = 0;
  logic [1:0] mux_signal;
  logic write_rp, write_rt, flush;
  logic [CNT_W-1:0] p_acerto, p_erro;

  int n_checks = 0;
  int n_fail = 0;

  branch_predict_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .hit_s1(hit_s1), .p_s1(p_s1), .hit_s4(hit_s4), .p_s4(p_s4),
    .branch_s4(branch_s4), .deviated_s4(deviated_s4),
    .mux_signal(mux_signal), .write_rp(write_rp), .write_rt(write_rt),
    .flush(flush), .p_acerto(p_acerto), .p_erro(p_erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outcome classes: a branch is correct when the effective prediction
  // (hit and taken) equals the outcome; a non-branch is wrong only when
  // something predicted taken for it.
  longint good_m = 0, bad_m = 0;

  function automatic bit m_wrong();
    bit predicted_taken = hit_s4 && p_s4;
    if (branch_s4) return predicted_taken != deviated_s4;
    return predicted_taken;
  endfunction

  function automatic int m_mux();
    if (m_wrong()) return (branch_s4 && deviated_s4) ? 3 : 2;
    return (hit_s1 && p_s1) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_m = 0;
      bad_m  = 0;
    end else if (STATS) begin
      if (m_wrong())      bad_m  = (bad_m  == CMAX) ? CMAX : bad_m + 1;
      else if (branch_s4) good_m = (good_m == CMAX) ? CMAX : good_m + 1;
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    chk("mux_signal", mux_signal, m_mux());
    chk("flush", flush, m_wrong());
    chk("write_rp", write_rp, branch_s4 && hit_s4);
    chk("write_rt", write_rt, branch_s4 && !hit_s4);
    chk("p_acerto", p_acerto, good_m);
    chk("p_erro", p_erro, bad_m);
  end

  // Drive a new s1/s4 input set just after a rising edge.
  task automatic drive(input bit h1, input bit pp1, input bit h4, input bit pp4,
                       input bit br, input bit dv);
    hit_s1 = h1; p_s1 = pp1; hit_s4 = h4; p_s4 = pp4; branch_s4 = br; deviated_s4 = dv;
    #1;
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state, inputs idle
    #3;
    chk("rst p_acerto", p_acerto, 0);
    chk("rst p_erro", p_erro, 0);
    chk("rst mux", mux_signal, 0);
    chk("rst flush", flush, 0);
    #10 rst_n = 1'b1;

    // Hit, predict taken at fetch, s4 idle
    next_edge();
    drive(1, 1, 0, 0, 0, 0);
    chk("s1 pred mux", mux_signal, 1);
    chk("s1 pred flush", flush, 0);

    // Correctly predicted taken branch
    next_edge();
    drive(1, 1, 1, 1, 1, 1);
    chk("ok mux", mux_signal, 1);
    chk("ok flush", flush, 0);
    chk("ok write_rp", write_rp, 1);
    chk("ok write_rt", write_rt, 0);

    // Predicted taken, actually not taken
    next_edge();
    chk("ok p_acerto", p_acerto, STATS ? 1 : 0);
    drive(1, 1, 1, 1, 1, 0);
    chk("nt mux", mux_signal, 2);
    chk("nt flush", flush, 1);
    chk("nt write_rp", write_rp, 1);

    // Table miss, branch taken
    next_edge();
    chk("nt p_erro", p_erro, STATS ? 1 : 0);
    drive(0, 0, 0, 0, 1, 1);
    chk("miss mux", mux_signal, 3);
    chk("miss flush", flush, 1);
    chk("miss write_rt", write_rt, 1);
    chk("miss write_rp", write_rp, 0);

    // Aliased entry predicting taken on a non-branch
    next_edge();
    chk("miss p_erro", p_erro, STATS ? 2 : 0);
    drive(0, 0, 1, 1, 0, 0);
    chk("alias mux", mux_signal, 2);
    chk("alias flush", flush, 1);
    chk("alias write_rp", write_rp, 0);
    chk("alias write_rt", write_rt, 0);

    next_edge();
    chk("alias p_erro", p_erro, STATS ? 3 : 0);
    chk("alias p_acerto", p_acerto, STATS ? 1 : 0);

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
            $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0));
      next_edge();
    end

`ifdef BP_STATS_EN
    // Saturation: preload the error counter near all-ones
    drive(0, 0, 0, 0, 0, 0);
    force dut.u_erro.cnt_q = 32'hFFFF_FFFD;
    #1 release dut.u_erro.cnt_q;
    bad_m = 64'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) begin
      next_edge();
      drive(0, 0, 0, 0, 1, 1);   // miss on a taken branch
    end
    next_edge();
    drive(0, 0, 0, 0, 0, 0);
    chk("sat p_erro", p_erro, 64'hFFFF_FFFF);
    next_edge();
    chk("sat hold p_erro", p_erro, 64'hFFFF_FFFF);
`endif

    // Asynchronous reset pulse between clock edges
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst p_acerto", p_acerto, 0);
    chk("arst p_erro", p_erro, 0);
    rst_n = 1'b1;
    next_edge();
    next_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
